// File: rtl/mem_exec_unit.sv
// Memory execution unit: computes the effective address for one issued
// load/store micro-op, runs the dmem request/response handshake and broadcasts load results.
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif

package mem_exec_pkg;
    localparam int PRF_W = `PRF_INT_INDEX_SIZE;

    typedef enum logic { MEM_LOAD = 1'b0, MEM_STORE = 1'b1 } mem_type_t;
    typedef enum logic [1:0] { SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2 } mem_size_t;

    typedef struct packed {
        logic             valid;
        mem_type_t        mem_type;
        mem_size_t        mem_size;
        logic             mem_signed;
        logic [11:0]      imm;
        logic [PRF_W-1:0] rd_prf_int_index;
    } micro_op_t;
endpackage

module mem_exec_unit
    import mem_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  micro_op_t                      uop_in,
    input  logic [XLEN-1:0]                rs1_data,
    input  logic [XLEN-1:0]                rs2_data,
    output logic                           ex_busy,
    output logic                           dmem_req_valid,
    input  logic                           dmem_req_ready,
    output logic [XLEN-1:0]                dmem_req_addr,
    output logic                           dmem_req_we,
    output logic [XLEN-1:0]                dmem_req_wdata,
    output logic [3:0]                     dmem_req_wstrb,
    input  logic                           dmem_resp_valid,
    input  logic [XLEN-1:0]                dmem_resp_rdata,
    output logic                           ctb_valid,
    output logic [`PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index,
    output logic [XLEN-1:0]                wb_data,
    output logic                           misaligned
);

    typedef enum logic [1:0] { IDLE, REQ, RESP, WB } state_t;

    state_t state, state_next;

    logic [XLEN-1:0]  addr_sum;
    logic             addr_bad;
    logic [3:0]       strb_calc;
    logic [XLEN-1:0]  wdata_calc;
    logic [XLEN-1:0]  lane;
    logic [XLEN-1:0]  result_calc;
    logic             accept;

    logic [XLEN-1:0]  addr_q;
    logic [1:0]       off_q;
    logic             we_q;
    logic [XLEN-1:0]  wdata_q;
    logic [3:0]       wstrb_q;
    mem_size_t        size_q;
    logic             signed_q;
    logic [PRF_W-1:0] tag_q;
    logic [XLEN-1:0]  result_q;
    logic             mis_q;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        addr_sum   = rs1_data + {{(XLEN-12){uop_in.imm[11]}}, uop_in.imm};
        addr_bad   = 1'b0;
        strb_calc  = 4'b1111;
        wdata_calc = rs2_data;
        case (uop_in.mem_size)
            SIZE_BYTE: begin
                strb_calc  = 4'b0001 << addr_sum[1:0];
                wdata_calc = {4{rs2_data[7:0]}};
            end
            SIZE_HALF: begin
                addr_bad   = addr_sum[0];
                strb_calc  = 4'b0011 << addr_sum[1:0];
                wdata_calc = {2{rs2_data[15:0]}};
            end
            default: addr_bad = (addr_sum[1:0] != 2'b00);
        endcase
        accept = (state == IDLE) && uop_in.valid;
    end

    // Response lane extract: shift the addressed byte/half down to bit 0, then extend.
    always_comb begin
        lane        = dmem_resp_rdata >> {off_q, 3'b000};
        result_calc = lane;
        case (size_q)
            SIZE_BYTE: result_calc = signed_q ? {{(XLEN-8){lane[7]}}, lane[7:0]}
                                              : {{(XLEN-8){1'b0}}, lane[7:0]};
            SIZE_HALF: result_calc = signed_q ? {{(XLEN-16){lane[15]}}, lane[15:0]}
                                              : {{(XLEN-16){1'b0}}, lane[15:0]};
            default:   result_calc = lane;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !addr_bad) state_next = REQ;
            REQ:  if (dmem_req_ready)      state_next = we_q ? IDLE : RESP;
            RESP: if (dmem_resp_valid)     state_next = WB;
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            off_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            mis_q <= accept && addr_bad;
            // A misaligned uop is dropped without disturbing the captured request fields.
            if (accept && !addr_bad) begin
                addr_q   <= {addr_sum[XLEN-1:2], 2'b00};
                off_q    <= addr_sum[1:0];
                we_q     <= (uop_in.mem_type == MEM_STORE);
                wdata_q  <= wdata_calc;
                wstrb_q  <= strb_calc;
                size_q   <= uop_in.mem_size;
                signed_q <= uop_in.mem_signed;
                tag_q    <= uop_in.rd_prf_int_index;
            end
            if (state == RESP && dmem_resp_valid) result_q <= result_calc;
        end
    end

    assign ex_busy           = (state != IDLE);
    assign dmem_req_valid    = (state == REQ);
    assign dmem_req_addr     = addr_q;
    assign dmem_req_we       = we_q;
    assign dmem_req_wdata    = wdata_q;
    assign dmem_req_wstrb    = wstrb_q;
    assign ctb_valid         = (state == WB);
    assign ctb_prf_int_index = tag_q;
    assign wb_data           = result_q;
    assign misaligned        = mis_q;

endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed self-checking bench for mem_exec_unit: loads, stores, backpressure,
// misalignment and reset during an outstanding load.
module tb_mem_exec_unit;
    import mem_exec_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    micro_op_t        uop_in;
    logic [31:0]      rs1_data, rs2_data;
    logic             ex_busy, dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0]      dmem_req_addr, dmem_req_wdata;
    logic [3:0]       dmem_req_wstrb;
    logic             dmem_resp_valid;
    logic [31:0]      dmem_resp_rdata;
    logic             ctb_valid;
    logic [PRF_W-1:0] ctb_prf_int_index;
    logic [31:0]      wb_data;
    logic             misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    mem_exec_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .uop_in(uop_in),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_busy(ex_busy),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .ctb_valid(ctb_valid), .ctb_prf_int_index(ctb_prf_int_index),
        .wb_data(wb_data), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // Offers one uop across a single posedge; returns at the following negedge.
    task automatic issue(input mem_type_t t, input mem_size_t sz, input logic sgn,
                         input logic [31:0] rs1, input logic [11:0] imm,
                         input logic [31:0] rs2, input logic [PRF_W-1:0] tag);
        @(negedge clock);
        uop_in.valid            = 1'b1;
        uop_in.mem_type         = t;
        uop_in.mem_size         = sz;
        uop_in.mem_signed       = sgn;
        uop_in.imm              = imm;
        uop_in.rd_prf_int_index = tag;
        rs1_data = rs1;
        rs2_data = rs2;
        @(posedge clock);
        @(negedge clock);
        uop_in.valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({ex_busy, dmem_req_valid, ctb_valid, misaligned, dmem_req_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {ex_busy, dmem_req_valid, ctb_valid, misaligned, dmem_req_we});
        end
        n_checks++;
        if ({dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, wb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%b wb=%h expected all 0",
                     dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, wb_data);
        end
        reset = 1'b0;
    endtask

    // Full load: request accepted immediately, response one cycle later, then ctb.
    task automatic do_load(input string name, input mem_size_t sz, input logic sgn,
                           input logic [31:0] rs1, input logic [11:0] imm,
                           input logic [PRF_W-1:0] tag, input logic [31:0] exp_addr,
                           input logic [31:0] rdata, input logic [31:0] exp_wb);
        issue(MEM_LOAD, sz, sgn, rs1, imm, 32'h0, tag);
        n_checks++;
        if ({dmem_req_valid, dmem_req_we, ex_busy} !== 3'b101 || dmem_req_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL %s_req: got v/we/busy=%b addr=%h expected 101 addr=%h",
                     name, {dmem_req_valid, dmem_req_we, ex_busy}, dmem_req_addr, exp_addr);
        end
        dmem_req_ready = 1'b1;
        @(negedge clock);
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        @(negedge clock);
        dmem_resp_valid = 1'b0;
        n_checks++;
        if (ctb_valid !== 1'b1 || wb_data !== exp_wb || ctb_prf_int_index !== tag) begin
            n_fail++;
            $display("FAIL %s_ctb: got v=%b wb=%h tag=%0d expected v=1 wb=%h tag=%0d",
                     name, ctb_valid, wb_data, ctb_prf_int_index, exp_wb, tag);
        end
        @(negedge clock);
        n_checks++;
        if ({ctb_valid, ex_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_done: got ctb/busy=%b expected 00", name, {ctb_valid, ex_busy});
        end
    endtask

    task automatic test_loads();
        do_load("lw",  SIZE_WORD, 1'b0, 32'h0000_1000, 12'h004, 6'd5,  32'h0000_1004,
                32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb",  SIZE_BYTE, 1'b1, 32'h0000_2010, 12'hFF3, 6'd9,  32'h0000_2000,
                32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("lbu", SIZE_BYTE, 1'b0, 32'h0000_2000, 12'h003, 6'd10, 32'h0000_2000,
                32'h80FF_FFFF, 32'h0000_0080);
        do_load("lh",  SIZE_HALF, 1'b1, 32'h0000_2000, 12'h002, 6'd11, 32'h0000_2000,
                32'h8001_7FFF, 32'hFFFF_8001);
    endtask

    task automatic test_store_half();
        issue(MEM_STORE, SIZE_HALF, 1'b0, 32'h0000_3000, 12'h002, 32'h1234_ABCD, 6'd7);
        n_checks++;
        if ({dmem_req_valid, dmem_req_we} !== 2'b11 || dmem_req_addr !== 32'h0000_3000 ||
            dmem_req_wstrb !== 4'b1100 || dmem_req_wdata !== 32'hABCD_ABCD) begin
            n_fail++;
            $display("FAIL sh_req: got v/we=%b addr=%h wstrb=%b wdata=%h expected 11 3000 1100 abcdabcd",
                     {dmem_req_valid, dmem_req_we}, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata);
        end
        dmem_req_ready = 1'b1;
        @(negedge clock);
        dmem_req_ready = 1'b0;
        n_checks++;
        if ({ex_busy, dmem_req_valid, ctb_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL sh_after: got busy/req/ctb=%b expected 000", {ex_busy, dmem_req_valid, ctb_valid});
        end
        @(negedge clock);
        n_checks++;
        if (ctb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_no_ctb: got %b expected 0", ctb_valid);
        end
    endtask

    task automatic test_store_byte();
        issue(MEM_STORE, SIZE_BYTE, 1'b0, 32'h0000_6001, 12'h000, 32'h0000_005A, 6'd3);
        n_checks++;
        if (dmem_req_wstrb !== 4'b0010 || dmem_req_wdata !== 32'h5A5A_5A5A || dmem_req_addr !== 32'h0000_6000) begin
            n_fail++;
            $display("FAIL sb_req: got wstrb=%b wdata=%h addr=%h expected 0010 5a5a5a5a 6000",
                     dmem_req_wstrb, dmem_req_wdata, dmem_req_addr);
        end
        dmem_req_ready = 1'b1;
        @(negedge clock);
        dmem_req_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        issue(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_4000, 12'h008, 32'h0, 6'd21);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                uop_in.valid            = 1'b1;
                uop_in.mem_type         = MEM_STORE;
                uop_in.mem_size         = SIZE_WORD;
                uop_in.imm              = 12'h000;
                uop_in.rd_prf_int_index = 6'd30;
                rs1_data = 32'h0000_5000;
                rs2_data = 32'hCAFE_F00D;
            end
            @(negedge clock);
            uop_in.valid = 1'b0;
            n_checks++;
            if ({dmem_req_valid, ex_busy, dmem_req_we} !== 3'b110 || dmem_req_addr !== 32'h0000_4008) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v/busy/we=%b addr=%h expected 110 addr=00004008",
                         i, {dmem_req_valid, ex_busy, dmem_req_we}, dmem_req_addr);
            end
        end
        dmem_req_ready = 1'b1;
        @(negedge clock);
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1122_3344;
        @(negedge clock);
        dmem_resp_valid = 1'b0;
        n_checks++;
        if (ctb_valid !== 1'b1 || wb_data !== 32'h1122_3344 || ctb_prf_int_index !== 6'd21) begin
            n_fail++;
            $display("FAIL bp_ctb: got v=%b wb=%h tag=%0d expected v=1 wb=11223344 tag=21",
                     ctb_valid, wb_data, ctb_prf_int_index);
        end
        repeat (2) begin
            @(negedge clock);
            n_checks++;
            if ({dmem_req_valid, ex_busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_ignored: got req/busy=%b expected 00", {dmem_req_valid, ex_busy});
            end
        end
    endtask

    task automatic test_misaligned();
        issue(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_1000, 12'h002, 32'h0, 6'd4);
        n_checks++;
        if ({misaligned, dmem_req_valid, ex_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL lw_mis: got mis/req/busy=%b expected 100", {misaligned, dmem_req_valid, ex_busy});
        end
        @(negedge clock);
        n_checks++;
        if ({misaligned, dmem_req_valid, ex_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL lw_mis_pulse: got mis/req/busy=%b expected 000", {misaligned, dmem_req_valid, ex_busy});
        end
        issue(MEM_STORE, SIZE_HALF, 1'b0, 32'h0000_3001, 12'h000, 32'h0, 6'd4);
        n_checks++;
        if ({misaligned, dmem_req_valid, ex_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL sh_mis: got mis/req/busy=%b expected 100", {misaligned, dmem_req_valid, ex_busy});
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        issue(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_7000, 12'h000, 32'h0, 6'd13);
        dmem_req_ready = 1'b1;
        @(negedge clock);
        dmem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset           = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h5555_AAAA;
        @(negedge clock);
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ctb_valid, ex_busy, dmem_req_valid} !== 3'b000 || wb_data !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_mid%0d: got ctb/busy/req=%b wb=%h expected 000 wb=0",
                         i, {ctb_valid, ex_busy, dmem_req_valid}, wb_data);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        uop_in          = '0;
        rs1_data        = '0;
        rs2_data        = '0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        test_reset();
        test_loads();
        test_store_half();
        test_store_byte();
        test_backpressure();
        test_misaligned();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
